// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-cache request/acknowledge handshake.
// Stalls the pipeline while a load/store waits for the cache, abandoning it after TIMEOUT cycles.
module ex_mem_stage #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       WB_i,
  input  logic [1:0]       MEM_i,
  input  logic [31:0]      ALUout_i,
  input  logic [31:0]      MemWriteData_i,
  input  logic [4:0]       RdAddr_i,
  input  logic             dcache_ack_i,
  input  logic [31:0]      dcache_rdata_i,
  output logic             dcache_req_o,
  output logic             dcache_we_o,
  output logic [31:0]      dcache_addr_o,
  output logic [31:0]      dcache_wdata_o,
  output logic             stall_o,
  output logic [1:0]       WB_o,
  output logic [31:0]      ALUout_o,
  output logic [31:0]      MemData_o,
  output logic [4:0]       RdAddr_o,
  output logic             RegWrite_FW_o,
  output logic             misalign_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [1:0]         wb_reg;
  logic               mem_we_reg;
  logic [31:0]        alu_reg;
  logic [31:0]        wdata_reg;
  logic [4:0]         rd_reg;
  logic               misalign_reg;
  logic               timeout_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;

  logic mem_op_in;
  logic wait_last;
  logic capture;
  logic timeout_hit;

  assign mem_op_in   = |MEM_i;
  assign wait_last   = (wait_reg == WAIT_W'(TIMEOUT - 1));
  assign capture     = !stall_o;
  assign timeout_hit = (state_reg == ACCESS) && !dcache_ack_i && wait_last;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state logic; an ack or timeout edge is also a capture edge, so a
  // memory op arriving on it starts its own access immediately.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        if (mem_op_in) begin
          state_next = ACCESS;
          wait_next  = '0;
        end
      end
      ACCESS: begin
        if (dcache_ack_i || wait_last) begin
          state_next = mem_op_in ? ACCESS : IDLE;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        wait_next  = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    dcache_req_o = 1'b0;
    dcache_we_o  = 1'b0;
    stall_o      = 1'b0;
    MemData_o    = '0;
    if (state_reg == ACCESS) begin
      dcache_req_o = 1'b1;
      dcache_we_o  = mem_we_reg;
      stall_o      = !dcache_ack_i && !wait_last;
      if (dcache_ack_i) MemData_o = dcache_rdata_i;
    end
  end

  // Pipeline register, sticky flags and stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_reg        <= '0;
      mem_we_reg    <= 1'b0;
      alu_reg       <= '0;
      wdata_reg     <= '0;
      rd_reg        <= '0;
      misalign_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (capture) begin
        wb_reg     <= WB_i;
        mem_we_reg <= MEM_i[0];
        alu_reg    <= ALUout_i;
        wdata_reg  <= MemWriteData_i;
        rd_reg     <= RdAddr_i;
        if (mem_op_in && (|ALUout_i[1:0])) misalign_reg <= 1'b1;
      end
      if (timeout_hit) timeout_reg <= 1'b1;
      if (stall_o && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign dcache_addr_o  = {alu_reg[31:2], 2'b00};
  assign dcache_wdata_o = wdata_reg;
  assign WB_o           = wb_reg;
  assign ALUout_o       = alu_reg;
  assign RdAddr_o       = rd_reg;
  assign RegWrite_FW_o  = wb_reg[1];
  assign misalign_o     = misalign_reg;
  assign timeout_o      = timeout_reg;
  assign stall_cnt_o    = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver pushes expected MEM/WB results,
// a negedge monitor pops and compares whenever the stage is not stalled.
module tb_ex_mem_stage;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       WB_i;
  logic [1:0]       MEM_i;
  logic [31:0]      ALUout_i;
  logic [31:0]      MemWriteData_i;
  logic [4:0]       RdAddr_i;
  logic             dcache_ack_i;
  logic [31:0]      dcache_rdata_i;
  logic             dcache_req_o;
  logic             dcache_we_o;
  logic [31:0]      dcache_addr_o;
  logic [31:0]      dcache_wdata_o;
  logic             stall_o;
  logic [1:0]       WB_o;
  logic [31:0]      ALUout_o;
  logic [31:0]      MemData_o;
  logic [4:0]       RdAddr_o;
  logic             RegWrite_FW_o;
  logic             misalign_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  ex_mem_stage #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .WB_i           (WB_i),
    .MEM_i          (MEM_i),
    .ALUout_i       (ALUout_i),
    .MemWriteData_i (MemWriteData_i),
    .RdAddr_i       (RdAddr_i),
    .dcache_ack_i   (dcache_ack_i),
    .dcache_rdata_i (dcache_rdata_i),
    .dcache_req_o   (dcache_req_o),
    .dcache_we_o    (dcache_we_o),
    .dcache_addr_o  (dcache_addr_o),
    .dcache_wdata_o (dcache_wdata_o),
    .stall_o        (stall_o),
    .WB_o           (WB_o),
    .ALUout_o       (ALUout_o),
    .MemData_o      (MemData_o),
    .RdAddr_o       (RdAddr_o),
    .RegWrite_FW_o  (RegWrite_FW_o),
    .misalign_o     (misalign_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] md;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   ack_delay = 0;   // cycles of req before ack; -1 = never
  int   ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Cache model: acks after ack_delay cycles of continuous request.
  always @(posedge clk_i) begin
    #1;
    if (!dcache_req_o) begin
      ack_cnt = 0;
      dcache_ack_i = 1'b0;
    end else if (ack_delay >= 0 && ack_cnt == ack_delay) begin
      dcache_ack_i = 1'b1;
      ack_cnt = 0;
    end else begin
      dcache_ack_i = 1'b0;
      ack_cnt++;
    end
  end

  exp_t e;
  always @(negedge clk_i) begin
    if (!rst_i && sb.size() > 0 && !stall_o) begin
      e = sb.pop_front();
      $display("txn wb=%b mem=%b alu=%h rd=%0d md=%h | got wb=%b alu=%h rd=%0d md=%h req=%b we=%b addr=%h",
               e.wb, e.mem, e.alu, e.rd, e.md, WB_o, ALUout_o, RdAddr_o, MemData_o,
               dcache_req_o, dcache_we_o, dcache_addr_o);
      chk("wb_o", 32'(WB_o), 32'(e.wb));
      chk("aluout_o", ALUout_o, e.alu);
      chk("rdaddr_o", 32'(RdAddr_o), 32'(e.rd));
      chk("regwrite_fw", 32'(RegWrite_FW_o), 32'(e.wb[1]));
      chk("memdata_o", MemData_o, e.md);
      chk("req", 32'(dcache_req_o), 32'(|e.mem));
      if (e.mem != 2'b00) begin
        chk("we", 32'(dcache_we_o), 32'(e.mem[0]));
        chk("addr", dcache_addr_o, e.addr);
        if (e.mem[0]) chk("wdata", dcache_wdata_o, e.wd);
      end
    end
  end

  // Drive one instruction, wait for its capture edge, then record the expectation.
  task automatic issue(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] md, input bit push);
    exp_t x;
    int n = 0;
    WB_i = wb; MEM_i = mem; ALUout_i = alu; MemWriteData_i = wd; RdAddr_i = rd;
    @(negedge clk_i);
    while (stall_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) chk("capture_wait", 32'(n), 32'd0);
    @(posedge clk_i);
    #1;
    x.wb = wb; x.mem = mem; x.alu = alu; x.wd = wd; x.rd = rd; x.addr = addr; x.md = md;
    if (push) sb.push_back(x);
    WB_i = 2'b00; MEM_i = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Count stalled cycles at negedges, starting in the current cycle.
  task automatic count_stall(output int cnt);
    cnt = 0;
    @(negedge clk_i);
    while (stall_o && cnt < 20) begin
      cnt++;
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
  endtask

  int sc;

  initial begin
    rst_i = 1'b1;
    WB_i = '0; MEM_i = '0; ALUout_i = '0; MemWriteData_i = '0; RdAddr_i = '0;
    dcache_ack_i = 1'b0; dcache_rdata_i = '0;
    idle(2);
    chk("rst_wb_o", 32'(WB_o), 32'd0);
    chk("rst_req", 32'(dcache_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    rst_i = 1'b0;

    // ALU op streams without stalling
    issue(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5, 32'h0, 32'h0, 1'b1);
    idle(1);

    // Load acked after 3 stall cycles
    ack_delay = 3;
    dcache_rdata_i = 32'hDEADBEEF;
    issue(2'b11, 2'b10, 32'h100, 32'h0, 5'd7, 32'h100, 32'hDEADBEEF, 1'b1);
    count_stall(sc);
    chk("load_stall_cycles", 32'(sc), 32'd3);
    idle(1);
    chk("load_stall_cnt", 32'(stall_cnt_o), 32'd3);
    chk("load_misalign", 32'(misalign_o), 32'd0);
    chk("load_timeout", 32'(timeout_o), 32'd0);

    // Reset in the middle of an access
    ack_delay = -1;
    issue(2'b11, 2'b10, 32'h200, 32'h0, 5'd2, 32'h200, 32'h0, 1'b0);
    @(negedge clk_i);
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_req", 32'(dcache_req_o), 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_wb_o", 32'(WB_o), 32'd0);
    chk("midrst_aluout", ALUout_o, 32'd0);
    chk("midrst_rdaddr", 32'(RdAddr_o), 32'd0);
    chk("midrst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Back-to-back store then load, ack always high
    ack_delay = 0;
    dcache_rdata_i = 32'h11112222;
    issue(2'b00, 2'b01, 32'h8, 32'hA5, 5'd0, 32'h8, 32'h11112222, 1'b1);
    issue(2'b11, 2'b10, 32'hC, 32'h0, 5'd3, 32'hC, 32'h11112222, 1'b1);
    idle(2);
    chk("b2b_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Misaligned load that times out
    ack_delay = -1;
    issue(2'b11, 2'b10, 32'h103, 32'h0, 5'd9, 32'h100, 32'h0, 1'b1);
    chk("misalign_set", 32'(misalign_o), 32'd1);
    count_stall(sc);
    chk("to_stall_cycles", 32'(sc), 32'd3);
    chk("timeout_set", 32'(timeout_o), 32'd1);
    chk("to_req_idle", 32'(dcache_req_o), 32'd0);
    chk("to_stall_cnt", 32'(stall_cnt_o), 32'd3);
    issue(2'b10, 2'b00, 32'h55, 32'h0, 5'd4, 32'h0, 32'h0, 1'b1);
    idle(1);

    // Second timeout: counter saturates at 3, flags stay sticky
    issue(2'b11, 2'b10, 32'h40, 32'h0, 5'd6, 32'h40, 32'h0, 1'b1);
    count_stall(sc);
    chk("sat_stall_cycles", 32'(sc), 32'd3);
    chk("sat_stall_cnt", 32'(stall_cnt_o), 32'd3);
    chk("sticky_timeout", 32'(timeout_o), 32'd1);
    chk("sticky_misalign", 32'(misalign_o), 32'd1);

    idle(3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
